// File: rtl/design_io_mux_n.sv
// Shares the user IO pads among NUM_DESIGNS macros behind one registered select,
// with an isolate / auto-reset handover on every switch. Optional macro: DESIGN_MUX_SYNC_EN.
module design_io_mux_n #(
  parameter int NUM_DESIGNS  = 6,
  parameter int SEL_W        = 4,
  parameter int IO_W         = 38,
  parameter int ISO_CYCLES   = 2,
  parameter int RESET_CYCLES = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [SEL_W-1:0]            i_mux_sel,
  input  logic                        i_mux_conf_strobe,
  input  logic                        i_mux_auto_reset_enb,
  input  logic [NUM_DESIGNS-1:0]      i_design_reset,
  input  logic [IO_W-1:0]             io_in,
  output logic [IO_W-1:0]             io_out,
  output logic [IO_W-1:0]             io_oeb,
  input  logic [NUM_DESIGNS*IO_W-1:0] design_io_out,
  input  logic [NUM_DESIGNS*IO_W-1:0] design_io_oeb,
  output logic [NUM_DESIGNS*IO_W-1:0] design_io_in,
  output logic [NUM_DESIGNS-1:0]      design_rst,
  output logic [SEL_W-1:0]            o_active_sel,
  output logic                        o_busy
);

  localparam int MAX_CYC = (ISO_CYCLES > RESET_CYCLES) ? ISO_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] ISO_LOAD   = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_RESET   = 2'd2
  } state_t;

  logic             strobe_in;
  logic [SEL_W-1:0] sel_in;
  logic             enb_in;

`ifdef DESIGN_MUX_SYNC_EN
  logic [1:0]       strobe_sync_q;
  logic [1:0]       enb_sync_q;
  logic [SEL_W-1:0] sel_s1_q, sel_s2_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      strobe_sync_q <= '0;
      enb_sync_q    <= '0;
      sel_s1_q      <= '0;
      sel_s2_q      <= '0;
    end else begin
      strobe_sync_q <= {strobe_sync_q[0], i_mux_conf_strobe};
      enb_sync_q    <= {enb_sync_q[0], i_mux_auto_reset_enb};
      sel_s1_q      <= i_mux_sel;
      sel_s2_q      <= sel_s1_q;
    end
  end

  assign strobe_in = strobe_sync_q[1];
  assign enb_in    = enb_sync_q[1];
  assign sel_in    = sel_s2_q;
`else
  assign strobe_in = i_mux_conf_strobe;
  assign enb_in    = i_mux_auto_reset_enb;
  assign sel_in    = i_mux_sel;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             strobe_prev_q;
  logic             strobe_edge;
  logic             sel_valid;
  logic             pads_live;

  assign strobe_edge = strobe_in & ~strobe_prev_q;
  assign sel_valid   = (sel_q < SEL_W'(NUM_DESIGNS));
  assign pads_live   = (state_q == ST_ACTIVE) && sel_valid;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_ACTIVE;
      cnt_q         <= '0;
      sel_q         <= '1;
      strobe_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      strobe_prev_q <= strobe_in;
    end
  end

  // A new edge always wins, so a switch in flight restarts with the newest code.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (strobe_edge) begin
      state_d = ST_ISOLATE;
      cnt_d   = ISO_LOAD;
      sel_d   = sel_in;
    end else begin
      case (state_q)
        ST_ISOLATE: begin
          if (cnt_q == '0) begin
            if (!enb_in && sel_valid) begin
              state_d = ST_RESET;
              cnt_d   = RESET_LOAD;
            end else begin
              state_d = ST_ACTIVE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RESET: begin
          if (cnt_q == '0) state_d = ST_ACTIVE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_ACTIVE: ;
        default:   state_d = ST_ACTIVE;
      endcase
    end
  end

  assign o_active_sel = sel_q;
  assign o_busy       = (state_q != ST_ACTIVE);

  logic [IO_W-1:0] sel_out, sel_oeb;

  always_comb begin
    sel_out = '0;
    sel_oeb = '1;
    for (int d = 0; d < NUM_DESIGNS; d++) begin
      if (sel_q == SEL_W'(d)) begin
        sel_out = design_io_out[d*IO_W +: IO_W];
        sel_oeb = design_io_oeb[d*IO_W +: IO_W];
      end
    end
  end

  always_comb begin
    design_io_in = '0;
    for (int d = 0; d < NUM_DESIGNS; d++) begin
      if (pads_live && (sel_q == SEL_W'(d))) design_io_in[d*IO_W +: IO_W] = io_in;
    end
  end

  logic [IO_W-1:0]        io_out_q, io_oeb_q;
  logic [NUM_DESIGNS-1:0] design_rst_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !pads_live) begin
      io_out_q <= '0;
      io_oeb_q <= '1;
    end else begin
      io_out_q <= sel_out;
      io_oeb_q <= sel_oeb;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      design_rst_q <= '1;
    end else begin
      for (int d = 0; d < NUM_DESIGNS; d++) begin
        design_rst_q[d] <= i_design_reset[d] | (sel_q != SEL_W'(d)) | (state_q != ST_ACTIVE);
      end
    end
  end

  assign io_out     = io_out_q;
  assign io_oeb     = io_oeb_q;
  assign design_rst = design_rst_q;

endmodule

// File: tb/tb_design_io_mux_n.sv
// Directed bench for design_io_mux_n in its default build (no input synchroniser).
module tb_design_io_mux_n;

  localparam int ND = 6;
  localparam int SW = 4;
  localparam int IW = 38;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [SW-1:0]        sel;
  logic                 strobe;
  logic                 enb;
  logic [ND-1:0]        man_rst;
  logic [IW-1:0]        pad_in;
  logic [IW-1:0]        pad_out, pad_oeb;
  logic [ND*IW-1:0]     d_out, d_oeb, d_in;
  logic [ND-1:0]        d_rst;
  logic [SW-1:0]        act_sel;
  logic                 busy;

  logic [IW-1:0] pat_out [ND];
  logic [IW-1:0] pat_oeb [ND];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  design_io_mux_n dut (
    .wb_clk_i             (clk),
    .wb_rst_i             (rst),
    .i_mux_sel            (sel),
    .i_mux_conf_strobe    (strobe),
    .i_mux_auto_reset_enb (enb),
    .i_design_reset       (man_rst),
    .io_in                (pad_in),
    .io_out               (pad_out),
    .io_oeb               (pad_oeb),
    .design_io_out        (d_out),
    .design_io_oeb        (d_oeb),
    .design_io_in         (d_in),
    .design_rst           (d_rst),
    .o_active_sel         (act_sel),
    .o_busy               (busy)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int d = 0; d < ND; d++) begin
      d_out[d*IW +: IW] = pat_out[d];
      d_oeb[d*IW +: IW] = pat_oeb[d];
    end
  endtask

  function automatic logic [ND*IW-1:0] exp_in(input int d);
    logic [ND*IW-1:0] e;
    e = '0;
    if (d >= 0 && d < ND) e[d*IW +: IW] = pad_in;
    return e;
  endfunction

  // Edge lands on the next posedge (cycle N); returns in the N+1 view.
  task automatic strobe_sel(input logic [SW-1:0] s);
    sel    = s;
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
  endtask

  localparam logic [IW-1:0] ONES = '1;

  initial begin
    bit d1_left_reset;

    rst = 1'b1; sel = '0; strobe = 1'b0; enb = 1'b0; man_rst = '0;
    pad_in = 38'h2A_DEAD_BEEF;
    for (int d = 0; d < ND; d++) begin
      pat_out[d] = {6'(d + 1), 32'hC0DE_0000 | 32'(d)};
      pat_oeb[d] = {6'h2A ^ 6'(d), 32'h0F0F_0000 | 32'(d << 4)};
    end
    pack();
    tick(3);

    chk("rst_oeb",  pad_oeb, ONES);
    chk("rst_out",  pad_out, '0);
    chk("rst_drst", d_rst,   6'b111111);
    chk("rst_sel",  act_sel, 4'hF);
    chk("rst_busy", busy,    1'b0);
    rst = 1'b0;
    tick(2);
    chk("park_din", d_in, '0);

    // sel=2 with auto-reset; strobe held high through the whole sequence
    sel = 4'd2; strobe = 1'b1;
    tick(1);
    chk("s2_busy_n1", busy, 1'b1);
    chk("s2_sel_n1",  act_sel, 4'd2);
    tick(17);
    chk("s2_busy_n18", busy, 1'b1);
    chk("s2_drst_n18", d_rst, 6'b111111);
    tick(1);
    chk("s2_busy_n19", busy, 1'b0);
    chk("s2_drst_n19", d_rst, 6'b111111);
    chk("s2_oeb_n19",  pad_oeb, ONES);
    tick(1);
    chk("s2_drst_n20", d_rst, 6'b111011);
    chk("s2_out_n20",  pad_out, pat_out[2]);
    chk("s2_oeb_n20",  pad_oeb, pat_oeb[2]);
    chk("s2_din",      d_in, exp_in(2));
    pat_out[2] = 38'h15_1234_5678;
    pack();
    chk("s2_lat_old", pad_out, {6'd3, 32'hC0DE_0002});
    tick(1);
    chk("s2_lat_new", pad_out, 38'h15_1234_5678);
    tick(3);
    chk("s2_held_busy", busy, 1'b0);
    strobe = 1'b0;
    tick(1);

    // auto-reset skipped, sel=4
    enb = 1'b1;
    strobe_sel(4'd4);
    chk("s4_busy_n1", busy, 1'b1);
    tick(1);
    chk("s4_busy_n2", busy, 1'b1);
    tick(1);
    chk("s4_busy_n3", busy, 1'b0);
    chk("s4_oeb_n3",  pad_oeb, ONES);
    tick(1);
    chk("s4_out_n4",  pad_out, pat_out[4]);
    chk("s4_oeb_n4",  pad_oeb, pat_oeb[4]);
    chk("s4_drst_n4", d_rst, 6'b101111);
    enb = 1'b0;
    tick(1);

    // sel=1 then restart with sel=3 at N+5
    d1_left_reset = 1'b0;
    strobe_sel(4'd1);
    if (!d_rst[1]) d1_left_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (!d_rst[1]) d1_left_reset = 1'b1;
    end
    strobe_sel(4'd3);
    chk("rs_sel_n6", act_sel, 4'd3);
    for (int i = 0; i < 17; i++) begin
      if (!d_rst[1]) d1_left_reset = 1'b1;
      tick(1);
    end
    chk("rs_busy_n23", busy, 1'b1);
    tick(1);
    chk("rs_busy_n24", busy, 1'b0);
    if (!d_rst[1]) d1_left_reset = 1'b1;
    tick(1);
    if (!d_rst[1]) d1_left_reset = 1'b1;
    chk("rs_d1_held", d1_left_reset, 1'b0);
    chk("rs_drst_n25", d_rst, 6'b110111);
    chk("rs_out_n25",  pad_out, pat_out[3]);

    // parked code
    strobe_sel(4'd9);
    chk("pk_busy_n1", busy, 1'b1);
    tick(1);
    chk("pk_busy_n2", busy, 1'b1);
    tick(1);
    chk("pk_busy_n3", busy, 1'b0);
    chk("pk_sel",     act_sel, 4'd9);
    tick(1);
    chk("pk_drst", d_rst, 6'b111111);
    chk("pk_oeb",  pad_oeb, ONES);
    chk("pk_out",  pad_out, '0);
    chk("pk_din",  d_in, '0);

    // manual reset pulse on design 0
    enb = 1'b1;
    strobe_sel(4'd0);
    tick(3);
    chk("m0_drst_pre", d_rst, 6'b111110);
    man_rst = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("m0_drst_hi", d_rst[0], 1'b1);
      chk("m0_busy",    busy, 1'b0);
      chk("m0_out",     pad_out, pat_out[0]);
      if (i == 2) man_rst = '0;
    end
    tick(1);
    chk("m0_drst_lo", d_rst, 6'b111110);
    enb = 1'b0;

    // synchronous reset in the middle of a switch
    strobe_sel(4'd5);
    tick(4);
    chk("mr_busy_pre", busy, 1'b1);
    rst = 1'b1;
    tick(1);
    chk("mr_busy", busy, 1'b0);
    chk("mr_sel",  act_sel, 4'hF);
    chk("mr_drst", d_rst, 6'b111111);
    chk("mr_oeb",  pad_oeb, ONES);
    chk("mr_out",  pad_out, '0);
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
